fifo_responder: RTL

FIFO_RESPONDER -- requirements
Module: fifo_responder

---
 rtl/fifo_responder.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/fifo_responder.sv
// Slave side of an asynchronous byte-wide FIFO strobe interface (FT245-style),
// bridging an RX queue filled by the host and a TX queue drained by the host.
module fifo_responder #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned PRECHARGE = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fifo_rd,
  input  logic       fifo_wr,
  output logic       fifo_rxf,
  output logic       fifo_txe,
  inout  wire  [7:0] fifo_data,
  input  logic [7:0] host_rx_data,
  input  logic       host_rx_valid,
  output logic       host_rx_ready,
  output logic [7:0] host_tx_data,
  output logic       host_tx_valid,
  input  logic       host_tx_ready,
  output logic       err_underrun,
  output logic       err_overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned PW = (PRECHARGE < 2) ? 1 : $clog2(PRECHARGE + 1);
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [PW-1:0] PRE_LOAD = PW'(PRECHARGE);

  logic          rd_s1, rd_s2, rd_s3;
  logic          wr_s1, wr_s2, wr_s3;
  logic [7:0]    data_s1, data_s2, data_s3;
  logic [1:0]    sync_fill;
  logic          rd_ok;

  logic [7:0]    rx_mem [DEPTH];
  logic [7:0]    tx_mem [DEPTH];
  logic [AW-1:0] rx_wp, rx_rp, tx_wp, tx_rp;
  logic [CW-1:0] rx_count, tx_count;
  logic [PW-1:0] rx_pre, tx_pre;

  logic edge_en_c, rd_fall_c, rd_rise_c, wr_fall_c;
  logic rx_push_c, rx_pop_c, tx_push_c, tx_pop_c, drive_c;

  // Edges are ignored until s2/s3 both hold post-reset samples, so a strobe
  // that straddles reset cannot fake an edge against the idle reset values.
  assign edge_en_c = (sync_fill == 2'd3);
  assign rd_fall_c = edge_en_c & rd_s3 & ~rd_s2;
  assign rd_rise_c = edge_en_c & ~rd_s3 & rd_s2;
  assign wr_fall_c = edge_en_c & wr_s3 & ~wr_s2;

  assign host_rx_ready = (rx_count != FULL);
  assign host_tx_valid = (tx_count != '0);
  assign host_tx_data  = tx_mem[tx_rp];

  assign rx_push_c = host_rx_valid & host_rx_ready;
  assign rx_pop_c  = rd_rise_c & rd_ok;
  assign tx_push_c = wr_fall_c & ~fifo_txe & (tx_count != FULL);
  assign tx_pop_c  = host_tx_valid & host_tx_ready;

  // Bus is driven from the raw strobe for fast access, and held until the
  // synchronised strobe catches up so the master sees stable data on release.
  assign drive_c   = (~fifo_rd & ~fifo_rxf) | (rd_ok & ~rd_s3);
  assign fifo_data = drive_c ? rx_mem[rx_rp] : 'z;

  // Queue storage; contents are meaningless once the counts are cleared.
  always_ff @(posedge clk) begin
    if (!reset && rx_push_c) rx_mem[rx_wp] <= host_rx_data;
    if (!reset && tx_push_c) tx_mem[tx_wp] <= data_s3;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_s1        <= 1'b1;
      rd_s2        <= 1'b1;
      rd_s3        <= 1'b1;
      wr_s1        <= 1'b0;
      wr_s2        <= 1'b0;
      wr_s3        <= 1'b0;
      data_s1      <= '0;
      data_s2      <= '0;
      data_s3      <= '0;
      sync_fill    <= '0;
      rd_ok        <= 1'b0;
      rx_wp        <= '0;
      rx_rp        <= '0;
      tx_wp        <= '0;
      tx_rp        <= '0;
      rx_count     <= '0;
      tx_count     <= '0;
      rx_pre       <= '0;
      tx_pre       <= '0;
      fifo_rxf     <= 1'b1;
      fifo_txe     <= 1'b0;
      err_underrun <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      rd_s1   <= fifo_rd;
      rd_s2   <= rd_s1;
      rd_s3   <= rd_s2;
      wr_s1   <= fifo_wr;
      wr_s2   <= wr_s1;
      wr_s3   <= wr_s2;
      data_s1 <= fifo_data;
      data_s2 <= data_s1;
      data_s3 <= data_s2;
      if (sync_fill != 2'd3) sync_fill <= sync_fill + 2'd1;

      if (rd_fall_c) begin
        rd_ok <= ~fifo_rxf;
        if (fifo_rxf) err_underrun <= 1'b1;
      end else if (rx_pop_c) begin
        rd_ok <= 1'b0;
      end
      if (wr_fall_c && !tx_push_c) err_overflow <= 1'b1;

      if (rx_push_c) rx_wp <= rx_wp + 1'b1;
      if (rx_pop_c)  rx_rp <= rx_rp + 1'b1;
      case ({rx_push_c, rx_pop_c})
        2'b10:   rx_count <= rx_count + CW'(1);
        2'b01:   rx_count <= rx_count - CW'(1);
        default: rx_count <= rx_count;
      endcase

      if (tx_push_c) tx_wp <= tx_wp + 1'b1;
      if (tx_pop_c)  tx_rp <= tx_rp + 1'b1;
      case ({tx_push_c, tx_pop_c})
        2'b10:   tx_count <= tx_count + CW'(1);
        2'b01:   tx_count <= tx_count - CW'(1);
        default: tx_count <= tx_count;
      endcase

      if (rx_pop_c)           rx_pre <= PRE_LOAD;
      else if (rx_pre != '0)  rx_pre <= rx_pre - PW'(1);
      if (tx_push_c)          tx_pre <= PRE_LOAD;
      else if (tx_pre != '0)  tx_pre <= tx_pre - PW'(1);

      fifo_rxf <= ~((rx_count != '0) && (rx_pre == '0));
      fifo_txe <= ~((tx_count != FULL) && (tx_pre == '0));
    end
  end

endmodule
